// File: rtl/vm_pkg.sv
// Shared types and constants for the vending-machine controller.
// Coin values are in 5-cent units.
package vm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_COLLECT  = 3'd1,
        ST_EVAL     = 3'd2,
        ST_DISPENSE = 3'd3,
        ST_REFUND   = 3'd4
    } vm_state_e;

    localparam int NICKEL_U  = 1;
    localparam int DIME_U    = 2;
    localparam int QUARTER_U = 5;
    localparam int PRICE_DEF = 4;
    localparam int COIN_W    = 3;

    // Yields zero unless exactly one coin line is high.
    function automatic logic [COIN_W-1:0] coin_units(input logic nickel,
                                                      input logic dime,
                                                      input logic quarter);
        logic [COIN_W-1:0] u;
        u = '0;
        case ({nickel, dime, quarter})
            3'b100:  u = COIN_W'(NICKEL_U);
            3'b010:  u = COIN_W'(DIME_U);
            3'b001:  u = COIN_W'(QUARTER_U);
            default: u = '0;
        endcase
        return u;
    endfunction

endpackage

// File: rtl/vm_price_cmp.sv
// Subtract-based price comparator: one borrow-extended subtraction
// gives less-than, equality and the change value together.
module vm_price_cmp #(
    parameter int W     = 4,
    parameter int PRICE = 4
) (
    input  logic [W-1:0] sum_i,
    output logic         eq_o,
    output logic         lt_o,
    output logic [W-1:0] diff_o
);

    logic [W:0] wide;

    assign wide   = {1'b0, sum_i} - {1'b0, W'(PRICE)};
    assign lt_o   = wide[W];
    assign eq_o   = (wide == '0);
    assign diff_o = wide[W-1:0];

endmodule

// File: rtl/vm_ctrl.sv
// Vending-machine sequencer: collects coins, evaluates credit against the
// price, then dispenses with change or refunds on cancel/timeout.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | no credit, waiting for the first coin
//   COLLECT  | credit below price, timeout counter running
//   EVAL     | one cycle comparing the freshly updated credit to the price
//   DISPENSE | soda (and change if any) presented until ack
//   REFUND   | whole credit presented as change until ack
module vm_ctrl
    import vm_pkg::*;
#(
    parameter int PRICE       = PRICE_DEF,
    parameter int SUM_W       = 4,
    parameter int TIMEOUT_CYC = 1000,
    parameter int TO_W        = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_nickel,
    input  logic             i_dime,
    input  logic             i_quarter,
    input  logic             i_cancel,
    input  logic             i_ack,
    output logic             o_soda,
    output logic [SUM_W-1:0] o_change,
    output logic             o_change_vld,
    output logic             o_coin_rej,
    output logic             o_busy,
    output logic [SUM_W-1:0] o_sum
);

    localparam logic [TO_W-1:0] TO_RELOAD = TO_W'(TIMEOUT_CYC);

    vm_state_e        state_q;
    logic [SUM_W-1:0] sum_q;
    logic [TO_W-1:0]  cnt_q;
    logic             soda_q;
    logic [SUM_W-1:0] change_q;
    logic             change_vld_q;
    logic             coin_rej_q;
    logic             busy_q;

    logic [1:0]       coin_cnt;
    logic             coin_any;
    logic             coin_one;
    logic             coin_multi;
    logic [SUM_W-1:0] sum_plus;
    logic             to_last;

    logic             cmp_eq;
    logic             cmp_lt;
    logic [SUM_W-1:0] cmp_diff;

    assign coin_cnt   = {1'b0, i_nickel} + {1'b0, i_dime} + {1'b0, i_quarter};
    assign coin_any   = (coin_cnt != 2'd0);
    assign coin_one   = (coin_cnt == 2'd1);
    assign coin_multi = (coin_cnt >= 2'd2);
    assign sum_plus   = sum_q + SUM_W'(coin_units(i_nickel, i_dime, i_quarter));
    assign to_last    = (cnt_q <= TO_W'(1));

    vm_price_cmp #(
        .W     (SUM_W),
        .PRICE (PRICE)
    ) u_cmp (
        .sum_i  (sum_q),
        .eq_o   (cmp_eq),
        .lt_o   (cmp_lt),
        .diff_o (cmp_diff)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            sum_q        <= '0;
            cnt_q        <= '0;
            soda_q       <= 1'b0;
            change_q     <= '0;
            change_vld_q <= 1'b0;
            coin_rej_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            coin_rej_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (coin_multi) begin
                        coin_rej_q <= 1'b1;
                    end else if (coin_one) begin
                        sum_q   <= sum_plus;
                        cnt_q   <= TO_RELOAD;
                        busy_q  <= 1'b1;
                        state_q <= ST_EVAL;
                    end
                end

                ST_COLLECT: begin
                    // Cancel takes priority over any coin in the same cycle.
                    if (i_cancel) begin
                        coin_rej_q   <= coin_any;
                        change_q     <= sum_q;
                        change_vld_q <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= ST_REFUND;
                    end else if (coin_one) begin
                        sum_q   <= sum_plus;
                        cnt_q   <= TO_RELOAD;
                        busy_q  <= 1'b1;
                        state_q <= ST_EVAL;
                    end else begin
                        coin_rej_q <= coin_multi;
                        if (to_last) begin
                            cnt_q        <= '0;
                            change_q     <= sum_q;
                            change_vld_q <= 1'b1;
                            busy_q       <= 1'b1;
                            state_q      <= ST_REFUND;
                        end else begin
                            cnt_q <= cnt_q - TO_W'(1);
                        end
                    end
                end

                ST_EVAL: begin
                    coin_rej_q <= coin_any;
                    if (cmp_lt) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_COLLECT;
                    end else begin
                        soda_q       <= 1'b1;
                        change_q     <= cmp_diff;
                        change_vld_q <= !cmp_eq;
                        state_q      <= ST_DISPENSE;
                    end
                end

                ST_DISPENSE, ST_REFUND: begin
                    coin_rej_q <= coin_any;
                    if (i_ack) begin
                        sum_q        <= '0;
                        soda_q       <= 1'b0;
                        change_q     <= '0;
                        change_vld_q <= 1'b0;
                        busy_q       <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_soda       = soda_q;
    assign o_change     = change_q;
    assign o_change_vld = change_vld_q;
    assign o_coin_rej   = coin_rej_q;
    assign o_busy       = busy_q;
    assign o_sum        = sum_q;

endmodule

// File: tb/tb_vm_ctrl.sv
// Bench for vm_ctrl: transaction-level credit model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_vm_ctrl;

    localparam int PRICE = 4;
    localparam int SUM_W = 4;
    localparam int TO    = 8;

    logic clk     = 1'b0;
    logic rst_n   = 1'b1;
    logic nickel  = 1'b0;
    logic dime    = 1'b0;
    logic quarter = 1'b0;
    logic cancel  = 1'b0;
    logic ack     = 1'b0;

    logic             soda;
    logic [SUM_W-1:0] change;
    logic             vld;
    logic             rej;
    logic             busy;
    logic [SUM_W-1:0] sum;

    int total = 0;
    int bad   = 0;
    bit go    = 1'b0;

    always #5 clk = ~clk;

    vm_ctrl #(
        .PRICE       (PRICE),
        .SUM_W       (SUM_W),
        .TIMEOUT_CYC (TO)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_nickel     (nickel),
        .i_dime       (dime),
        .i_quarter    (quarter),
        .i_cancel     (cancel),
        .i_ack        (ack),
        .o_soda       (soda),
        .o_change     (change),
        .o_change_vld (vld),
        .o_coin_rej   (rej),
        .o_busy       (busy),
        .o_sum        (sum)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: credit, an evaluation pending, or a payout owed (soda + change).
    int m_credit, m_idle_left, m_pay_change;
    bit m_eval, m_pay, m_pay_soda, m_rej;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_credit = 0; m_idle_left = 0; m_pay_change = 0;
            m_eval = 0; m_pay = 0; m_pay_soda = 0; m_rej = 0;
        end else begin
            int n, val;
            n   = int'(nickel) + int'(dime) + int'(quarter);
            val = int'(nickel) * 1 + int'(dime) * 2 + int'(quarter) * 5;
            m_rej = 0;
            if (m_pay) begin
                m_rej = (n > 0);
                if (ack) begin m_pay = 0; m_credit = 0; end
            end else if (m_eval) begin
                m_rej  = (n > 0);
                m_eval = 0;
                if (m_credit >= PRICE) begin
                    m_pay = 1; m_pay_soda = 1; m_pay_change = m_credit - PRICE;
                end
            end else if (m_credit == 0) begin
                if (n > 1) m_rej = 1;
                else if (n == 1) begin m_credit += val; m_eval = 1; m_idle_left = TO; end
            end else begin
                if (cancel) begin
                    m_rej = (n > 0);
                    m_pay = 1; m_pay_soda = 0; m_pay_change = m_credit;
                end else if (n == 1) begin
                    m_credit += val; m_eval = 1; m_idle_left = TO;
                end else begin
                    m_rej = (n > 1);
                    m_idle_left--;
                    if (m_idle_left == 0) begin
                        m_pay = 1; m_pay_soda = 0; m_pay_change = m_credit;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (go) begin
            chk("m_soda",   int'(soda),   int'(m_pay && m_pay_soda));
            chk("m_change", int'(change), m_pay ? m_pay_change : 0);
            chk("m_vld",    int'(vld),    int'(m_pay && (m_pay_change != 0 || !m_pay_soda)));
            chk("m_rej",    int'(rej),    int'(m_rej));
            chk("m_busy",   int'(busy),   int'(m_eval || m_pay));
            chk("m_sum",    int'(sum),    m_credit);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic coin(input logic n, input logic d, input logic q, input logic c);
        nickel = n; dime = d; quarter = q; cancel = c;
        @(negedge clk);
        nickel = 0; dime = 0; quarter = 0; cancel = 0;
    endtask

    task automatic do_ack();
        ack = 1;
        @(negedge clk);
        ack = 0;
    endtask

    initial begin
        #1 rst_n = 0;
        go = 1;
        cyc(2);
        rst_n = 1;
        cyc(1);
        chk("rst_sum",  int'(sum),  0);
        chk("rst_soda", int'(soda), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_vld",  int'(vld),  0);

        // four nickels, one every three cycles
        for (int i = 0; i < 4; i++) begin
            coin(1, 0, 0, 0);
            if (i < 3) cyc(2);
        end
        chk("t1_eval_sum",  int'(sum),  4);
        chk("t1_eval_soda", int'(soda), 0);
        cyc(1);
        chk("t1_soda",   int'(soda),   1);
        chk("t1_vld",    int'(vld),    0);
        chk("t1_change", int'(change), 0);
        do_ack();
        chk("t1_sum_clr",  int'(sum),  0);
        chk("t1_soda_clr", int'(soda), 0);
        chk("t1_busy_clr", int'(busy), 0);

        // dime then quarter: credit 7, change 3
        coin(0, 1, 0, 0); cyc(1);
        coin(0, 0, 1, 0); cyc(1);
        chk("t2_soda",   int'(soda),   1);
        chk("t2_change", int'(change), 3);
        chk("t2_vld",    int'(vld),    1);
        do_ack();
        chk("t2_change_clr", int'(change), 0);
        chk("t2_vld_clr",    int'(vld),    0);

        // single quarter, nickel during dispense is rejected
        coin(0, 0, 1, 0); cyc(1);
        chk("t3_change", int'(change), 1);
        coin(1, 0, 0, 0);
        chk("t3_rej",        int'(rej),    1);
        chk("t3_change_keep", int'(change), 1);
        chk("t3_sum_keep",   int'(sum),    5);
        cyc(1);
        chk("t3_rej_pulse", int'(rej), 0);
        do_ack();

        // dime + nickel then cancel: refund 3
        coin(0, 1, 0, 0); cyc(1);
        coin(1, 0, 0, 0); cyc(1);
        coin(0, 0, 0, 1);
        chk("t4_change", int'(change), 3);
        chk("t4_vld",    int'(vld),    1);
        chk("t4_soda",   int'(soda),   0);
        do_ack();
        // cancel coincident with a dime
        coin(0, 1, 0, 0); cyc(1);
        coin(1, 0, 0, 0); cyc(1);
        coin(0, 1, 0, 1);
        chk("t4b_rej",    int'(rej),    1);
        chk("t4b_change", int'(change), 3);
        chk("t4b_sum",    int'(sum),    3);
        do_ack();

        // ack already high when dispense starts: exactly one soda cycle
        ack = 1;
        coin(0, 0, 1, 0); cyc(1);
        chk("t5_soda_one", int'(soda), 1);
        cyc(1);
        chk("t5_soda_off", int'(soda), 0);
        chk("t5_sum_off",  int'(sum),  0);
        ack = 0;

        // timeout after 8 idle collect cycles
        coin(1, 0, 0, 0);
        cyc(8);
        chk("t6_not_yet", int'(vld), 0);
        cyc(1);
        chk("t6_vld",    int'(vld),    1);
        chk("t6_change", int'(change), 1);
        chk("t6_soda",   int'(soda),   0);
        do_ack();
        // two coins at once
        coin(1, 1, 0, 0);
        chk("t6_multi_rej_idle", int'(rej), 1);
        chk("t6_multi_sum_idle", int'(sum), 0);
        coin(1, 0, 0, 0); cyc(1);
        coin(1, 1, 0, 0);
        chk("t6_multi_rej", int'(rej), 1);
        chk("t6_multi_sum", int'(sum), 1);
        coin(0, 0, 0, 1);
        chk("t6_refund", int'(change), 1);
        do_ack();

        // reset in the middle of a dispense
        coin(0, 1, 0, 0); cyc(1);
        coin(0, 0, 1, 0); cyc(1);
        chk("t7_pre_soda", int'(soda), 1);
        #2 rst_n = 0;
        #1;
        chk("t7_async_soda",   int'(soda),   0);
        chk("t7_async_change", int'(change), 0);
        chk("t7_async_sum",    int'(sum),    0);
        chk("t7_async_busy",   int'(busy),   0);
        @(negedge clk);
        rst_n = 1;
        cyc(1);
        chk("t7_idle_sum", int'(sum), 0);
        coin(1, 0, 0, 0);
        chk("t7_next_sum", int'(sum), 1);
        cyc(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
